// File: rtl/brisc_pkg.sv
// Shared core widths and the writeback entry type.
// Also holds the default sizing of the writeback arbiter.
package brisc_pkg;

    localparam int XLEN       = 32;
    localparam int REG_BITS   = 5;
    localparam int WB_NUM_SRC = 2;
    localparam int WB_DEPTH   = 2;

    typedef struct packed {
        logic [REG_BITS-1:0] rd;
        logic [XLEN-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Single-channel synchronous FIFO for writeback entries.
// Flush and reset both empty it; push and pop may occur in the same cycle.
module wb_src_fifo
    import brisc_pkg::*;
#(
    parameter int  DEPTH   = WB_DEPTH,
    parameter type entry_t = wb_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  entry_t                   data_i,
    output entry_t                   data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     count_q;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: NUM_SRC result channels, each buffered in a small FIFO,
// merged round-robin onto one registered register-file write port.
module wb_arbiter
    import brisc_pkg::*;
#(
    parameter int NUM_SRC  = WB_NUM_SRC,
    parameter int DEPTH    = WB_DEPTH,
    parameter int XLEN     = brisc_pkg::XLEN,
    parameter int REG_BITS = brisc_pkg::REG_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_in,
    input  logic [NUM_SRC-1:0]            src_valid_in,
    output logic [NUM_SRC-1:0]            src_ready_out,
    input  logic [NUM_SRC*REG_BITS-1:0]   src_rd_in,
    input  logic [NUM_SRC*XLEN-1:0]       src_data_in,
    output logic                          reg_write_out,
    output logic [REG_BITS-1:0]           rd_out,
    output logic [XLEN-1:0]               result_out,
    output logic [$clog2(NUM_SRC)-1:0]    grant_src_out,
    output logic                          conflict_out
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [REG_BITS-1:0] rd;
        logic [XLEN-1:0]     data;
    } entry_t;

    entry_t              head [NUM_SRC];
    logic [CNT_W-1:0]    fifo_count [NUM_SRC];
    logic [NUM_SRC-1:0]  fifo_empty;
    logic [NUM_SRC-1:0]  fifo_full;
    logic [NUM_SRC-1:0]  head_valid;
    logic [NUM_SRC-1:0]  push;
    logic [NUM_SRC-1:0]  grant;

    logic                hi_found;
    logic                lo_found;
    logic [IDX_W-1:0]    hi_idx;
    logic [IDX_W-1:0]    lo_idx;
    logic                found;
    logic                multi;
    logic [IDX_W-1:0]    winner;
    entry_t              win_entry;

    logic                reg_write_q;
    logic                conflict_q;
    logic [REG_BITS-1:0] rd_q;
    logic [XLEN-1:0]     result_q;
    logic [IDX_W-1:0]    grant_src_q;
    logic [IDX_W-1:0]    rr_ptr_q;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            entry_t in_entry;

            assign in_entry.rd   = src_rd_in[i*REG_BITS +: REG_BITS];
            assign in_entry.data = src_data_in[i*XLEN +: XLEN];

            // Ready comes from the registered count only, never from this cycle's grant.
            assign src_ready_out[i] = (fifo_count[i] != FULL_CNT);
            assign push[i] = src_valid_in[i] && src_ready_out[i] && (in_entry.rd != '0);

            wb_src_fifo #(
                .DEPTH   (DEPTH),
                .entry_t (entry_t)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .flush_i (flush_in),
                .push_i  (push[i]),
                .pop_i   (grant[i]),
                .data_i  (in_entry),
                .data_o  (head[i]),
                .full_o  (fifo_full[i]),
                .empty_o (fifo_empty[i]),
                .count_o (fifo_count[i])
            );
        end
    endgenerate

    assign head_valid = ~fifo_empty;
    assign multi      = ($countones(head_valid) > 1);

    // Lowest candidate above rr_ptr wins; otherwise wrap to the lowest candidate overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (head_valid[j]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(j);
                if (IDX_W'(j) > rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(j);
                end
            end
        end
        found  = lo_found;
        winner = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        grant     = '0;
        win_entry = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (found && (winner == IDX_W'(j))) begin
                grant[j]  = 1'b1;
                win_entry = head[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_in) begin
            reg_write_q <= 1'b0;
            conflict_q  <= 1'b0;
            rd_q        <= '0;
            result_q    <= '0;
            grant_src_q <= '0;
            rr_ptr_q    <= IDX_W'(NUM_SRC - 1);
        end else begin
            reg_write_q <= found;
            conflict_q  <= multi;
            if (found) begin
                rd_q        <= win_entry.rd;
                result_q    <= win_entry.data;
                grant_src_q <= winner;
                rr_ptr_q    <= winner;
            end
        end
    end

    assign reg_write_out = reg_write_q;
    assign conflict_out  = conflict_q;
    assign rd_out        = rd_q;
    assign result_out    = result_q;
    assign grant_src_out = grant_src_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(grant));
            assert ((push & fifo_full) == '0);
            assert ((grant & fifo_empty) == '0);
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic checked cycle by
// cycle against a queue-based reference model (2 channels), and an RR check on 3 channels.
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        flush2;
    logic [1:0]  valid2, ready2;
    logic [9:0]  rd2;
    logic [63:0] data2;
    logic        we2, conf2, gs2;
    logic [4:0]  rdo2;
    logic [31:0] res2;

    logic        flush3;
    logic [2:0]  valid3, ready3;
    logic [14:0] rd3;
    logic [95:0] data3;
    logic        we3, conf3;
    logic [1:0]  gs3;
    logic [4:0]  rdo3;
    logic [31:0] res3;

    wb_arbiter #(.NUM_SRC(2), .DEPTH(DEPTH), .XLEN(32), .REG_BITS(5)) dut2 (
        .clk(clk), .reset(reset), .flush_in(flush2),
        .src_valid_in(valid2), .src_ready_out(ready2),
        .src_rd_in(rd2), .src_data_in(data2),
        .reg_write_out(we2), .rd_out(rdo2), .result_out(res2),
        .grant_src_out(gs2), .conflict_out(conf2)
    );

    wb_arbiter #(.NUM_SRC(3), .DEPTH(DEPTH), .XLEN(32), .REG_BITS(5)) dut3 (
        .clk(clk), .reset(reset), .flush_in(flush3),
        .src_valid_in(valid3), .src_ready_out(ready3),
        .src_rd_in(rd3), .src_data_in(data3),
        .reg_write_out(we3), .rd_out(rdo3), .result_out(res3),
        .grant_src_out(gs3), .conflict_out(conf3)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one queue per channel, holding everything accepted and not yet written.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq [2][$];
    int          m_last;
    logic        m_we, m_conf, m_gs;
    logic [4:0]  m_rd;
    logic [31:0] m_res;

    task automatic model_clear();
        for (int i = 0; i < 2; i++) mq[i].delete();
        m_last = 1;
        m_we = 1'b0; m_conf = 1'b0; m_gs = 1'b0; m_rd = '0; m_res = '0;
    endtask

    function automatic logic [1:0] m_ready();
        logic [1:0] r;
        for (int i = 0; i < 2; i++) r[i] = (mq[i].size() != DEPTH);
        return r;
    endfunction

    task automatic model_cycle(input logic [1:0] v, input logic [9:0] rd,
                               input logic [63:0] d, input logic fl);
        logic [1:0] rdy;
        int   win;
        int   nonempty;
        ent_t e;
        rdy = m_ready();
        if (fl) begin
            model_clear();
            return;
        end
        nonempty = 0;
        for (int i = 0; i < 2; i++) if (mq[i].size() > 0) nonempty++;
        win = -1;
        for (int k = 1; k <= 2; k++) begin
            int c;
            c = (m_last + k) % 2;
            if (win < 0 && mq[c].size() > 0) win = c;
        end
        m_conf = (nonempty >= 2);
        if (win >= 0) begin
            e      = mq[win].pop_front();
            m_we   = 1'b1;
            m_rd   = e.rd;
            m_res  = e.data;
            m_gs   = (win == 1);
            m_last = win;
        end else begin
            m_we = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            e.rd   = rd[i*5 +: 5];
            e.data = d[i*32 +: 32];
            if (v[i] && rdy[i] && e.rd != 5'd0) mq[i].push_back(e);
        end
    endtask

    task automatic cyc2(input logic [1:0] v, input logic [9:0] rd,
                        input logic [63:0] d, input logic fl);
        valid2 = v; rd2 = rd; data2 = d; flush2 = fl;
        chk("src_ready", 64'(ready2), 64'(m_ready()));
        tick();
        model_cycle(v, rd, d, fl);
        chk("reg_write", 64'(we2), 64'(m_we));
        chk("conflict", 64'(conf2), 64'(m_conf));
        chk("rd_out", 64'(rdo2), 64'(m_rd));
        chk("result", 64'(res2), 64'(m_res));
        chk("grant_src", 64'(gs2), 64'(m_gs));
    endtask

    task automatic idle2();
        cyc2(2'b00, 10'd0, 64'd0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid2 = '0; rd2 = '0; data2 = '0; flush2 = 1'b0;
        valid3 = '0; rd3 = '0; data3 = '0; flush3 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int seq0, seq1, w1;
        int gcnt [3];
        logic [1:0]  rdy, rv;
        logic [4:0]  ra, rb;

        reset = 1'b1;
        valid2 = '0; rd2 = '0; data2 = '0; flush2 = 1'b0;
        valid3 = '0; rd3 = '0; data3 = '0; flush3 = 1'b0;

        // Reset state
        do_reset();
        chk("rst_we", 64'(we2), 64'd0);
        chk("rst_rd", 64'(rdo2), 64'd0);
        chk("rst_result", 64'(res2), 64'd0);
        chk("rst_grant", 64'(gs2), 64'd0);
        chk("rst_conflict", 64'(conf2), 64'd0);
        chk("rst_ready2", 64'(ready2), 64'h3);
        chk("rst_ready3", 64'(ready3), 64'h7);

        // Single write, two-cycle latency
        cyc2(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEAD_BEEF}, 1'b0);
        idle2();
        chk("single_we", 64'(we2), 64'd1);
        chk("single_rd", 64'(rdo2), 64'd5);
        chk("single_result", 64'(res2), 64'hDEAD_BEEF);
        chk("single_grant", 64'(gs2), 64'd0);
        chk("single_conflict", 64'(conf2), 64'd0);
        idle2();
        chk("single_we_drop", 64'(we2), 64'd0);
        chk("single_rd_hold", 64'(rdo2), 64'd5);

        // Two channels in the same cycle
        do_reset();
        cyc2(2'b11, {5'd2, 5'd1}, {32'h22, 32'h11}, 1'b0);
        idle2();
        chk("dual_we0", 64'(we2), 64'd1);
        chk("dual_rd0", 64'(rdo2), 64'd1);
        chk("dual_res0", 64'(res2), 64'h11);
        chk("dual_conf0", 64'(conf2), 64'd1);
        idle2();
        chk("dual_we1", 64'(we2), 64'd1);
        chk("dual_rd1", 64'(rdo2), 64'd2);
        chk("dual_res1", 64'(res2), 64'h22);
        chk("dual_grant1", 64'(gs2), 64'd1);
        chk("dual_conf1", 64'(conf2), 64'd0);
        idle2();
        chk("dual_idle", 64'(we2), 64'd0);

        // Saturation: channel 1 backpressure and in-order delivery
        do_reset();
        seq0 = 0; seq1 = 0; w1 = 0;
        for (int k = 0; k < 18; k++) begin
            rdy = m_ready();
            if (k == 2) chk("sat_ready1_low", 64'(ready2[1]), 64'd0);
            if (k < 12)
                cyc2(2'b11, {5'(16 + seq1), 5'(1 + seq0)},
                     {32'(32'h100 + seq1), 32'(seq0)}, 1'b0);
            else
                idle2();
            if (k < 12 && rdy[0]) seq0++;
            if (k < 12 && rdy[1]) seq1++;
            if (we2 && gs2) begin
                chk("sat_order1", 64'(rdo2), 64'(16 + w1));
                w1++;
            end
        end
        chk("sat_count1", 64'(w1), 64'(seq1));

        // x0 destination: accepted, never written
        do_reset();
        chk("x0_ready", 64'(ready2[0]), 64'd1);
        cyc2(2'b01, {5'd0, 5'd0}, {32'h0, 32'h1234}, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle2();
            chk("x0_no_write", 64'(we2), 64'd0);
        end

        // Flush with queued entries and same-cycle new valids
        do_reset();
        cyc2(2'b11, {5'd4, 5'd3}, {32'h44, 32'h33}, 1'b0);
        cyc2(2'b11, {5'd7, 5'd6}, {32'h77, 32'h66}, 1'b1);
        chk("flush_ready", 64'(ready2), 64'h3);
        chk("flush_we", 64'(we2), 64'd0);
        for (int k = 0; k < 5; k++) begin
            idle2();
            chk("flush_no_write", 64'(we2), 64'd0);
        end

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rv = 2'($urandom);
            ra = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rb = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cyc2(rv, {rb, ra}, {32'($urandom), 32'($urandom)}, (($urandom % 40) == 0));
        end
        for (int k = 0; k < 6; k++) idle2();

        // Three channels, all valid for 9 cycles: grants rotate 0,1,2
        do_reset();
        for (int i = 0; i < 3; i++) gcnt[i] = 0;
        for (int t = 0; t <= 9; t++) begin
            valid3 = (t <= 8) ? 3'b111 : 3'b000;
            rd3    = {5'd3, 5'd2, 5'd1};
            data3  = {32'hC, 32'hB, 32'hA};
            tick();
            if (t >= 1) begin
                chk("rr3_we", 64'(we3), 64'd1);
                chk("rr3_grant", 64'(gs3), 64'((t - 1) % 3));
                if (gs3 < 2'd3) gcnt[gs3]++;
            end
            if (t == 1) chk("rr3_conflict", 64'(conf3), 64'd1);
        end
        for (int i = 0; i < 3; i++) chk("rr3_count", 64'(gcnt[i]), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Parametrised writeback stage that merges NUM_SRC independent result channels (ALU, MUL, future FPU/DIV, ...) onto one register-file write port.
- Each channel feeds a small per-channel FIFO with a valid/ready handshake, so units that complete in the same cycle are serialised rather than dropped or prioritised silently.
- A round-robin arbiter picks one FIFO head per cycle into a registered write port.
- Sits after the commit/cache stage, in place of the fixed two-channel writeback.

Parameters:
- NUM_SRC, 2, number of result channels (>=2).
- DEPTH, 2, entries per channel FIFO (power of two, >=2).
- XLEN, brisc_pkg::XLEN, data width.
- REG_BITS, brisc_pkg::REG_BITS, destination register index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush_in  in  1  synchronous pipeline flush; discards all queued and output state
- src_valid_in  in  NUM_SRC  channel i presents a result
- src_ready_out  out  NUM_SRC  channel i FIFO can accept
- src_rd_in  in  NUM_SRC*REG_BITS  destination register, channel i at bits [i*REG_BITS +: REG_BITS]
- src_data_in  in  NUM_SRC*XLEN  result value, channel i at [i*XLEN +: XLEN]
- reg_write_out  out  1  register-file write enable
- rd_out  out  REG_BITS  write address
- result_out  out  XLEN  write data
- grant_src_out  out  $clog2(NUM_SRC)  channel index of current write (debug/forwarding tag)
- conflict_out  out  1  pulses the cycle more than one FIFO head is valid

Behaviour:
- Reset/flush state:
  - All FIFOs empty (rd/wr pointers and count = 0).
  - reg_write_out = 0, rd_out = 0, result_out = 0, grant_src_out = 0, conflict_out = 0.
  - RR pointer = NUM_SRC-1, so channel 0 has first priority.
  - flush_in has identical effect to reset and overrides any same-cycle accept or grant.
- Handshake:
  - Transfer on channel i when src_valid_in[i] && src_ready_out[i].
  - src_ready_out[i] = (count_i != DEPTH), derived from registered count only. No combinational path from grant to ready.
  - A transfer with src_rd_in == 0 is accepted (ready honoured) but not enqueued; x0 writes are never issued.
- Enqueue: accepted entry is written at the clock edge ending cycle N and is a FIFO head candidate in cycle N+1.
- Arbitration (combinational, cycle N+1):
  - Candidates are non-empty FIFO heads.
  - Search starts at (rr_ptr+1) mod NUM_SRC and wraps; the first candidate wins.
  - On a grant: dequeue the winner's head and set rr_ptr = winner.
  - No candidate: rr_ptr unchanged.
- Output register (loaded at the edge ending cycle N+1):
  - reg_write_out = any grant.
  - rd_out / result_out / grant_src_out = winner's entry.
  - Minimum input-to-write latency is 2 cycles.
  - With no grant: reg_write_out = 0 and rd_out/result_out/grant_src_out hold their previous values.
- conflict_out is registered alongside the output: 1 when ≥2 heads were valid in the arbitration cycle.
- Simultaneous enqueue and dequeue on a full FIFO:
  - Enqueue is blocked, because ready was low.
  - Count goes DEPTH-1 the next cycle, so ready rises one cycle later.
- Simultaneous enqueue and dequeue on a non-full FIFO: count unchanged, pointers both advance.
- Pointers: wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- Throughput: one write per cycle total. Each channel is guaranteed a grant within NUM_SRC cycles of reaching its head (starvation-free).
- Ordering: within a channel, strictly FIFO. Across channels, no ordering guarantee; the issue logic must not issue same-rd WAW across channels.
- Assertions (simulation only):
  - No enqueue when full.
  - No dequeue when empty.
  - Grant is one-hot or zero.

Decomposition:
- brisc_pkg: XLEN and REG_BITS, plus new typedef wb_entry_t {logic [REG_BITS-1:0] rd; logic [XLEN-1:0] data;}. Also add WB_NUM_SRC and WB_DEPTH defaults.
- Sub-module wb_src_fifo: single-channel synchronous FIFO of wb_entry_t with DEPTH, push/pop, full/empty/count and flush. Instantiated NUM_SRC times in a generate loop.
- The round-robin search stays inline in wb_arbiter.

Test Plan:
- Reset, then channel 0 sends rd=5, data=0xDEAD_BEEF at cycle 1 -> cycle 3: reg_write_out=1, rd_out=5, result_out=0xDEADBEEF, grant_src_out=0, conflict_out=0; cycle 4: reg_write_out=0.
- Channels 0 and 1 both send once in cycle 1 (rd=1/0x11, rd=2/0x22) -> cycle 3 writes rd=1 with conflict_out=1; cycle 4 writes rd=2 with conflict_out=0.
- Channel 1 drives valid continuously with DEPTH=2 and arbiter saturated by channels 0 and 1 -> src_ready_out[1] drops after 2 accepted entries. No entry lost or duplicated. Write order on channel 1 matches send order.
- Channel 0 sends rd=0, data=0x1234 -> accepted (ready=1), no reg_write_out pulse ever.
- Three entries queued across channels, flush_in asserted with a same-cycle new valid on channel 0 -> next cycle all src_ready_out=1, reg_write_out=0, and no queued or same-cycle entry is ever written.
- NUM_SRC=3, all channels valid every cycle for 9 cycles -> grants cycle 0,1,2,0,1,2,...; each channel gets exactly 3 writes.
